hazard_scoreboard: RTL

- Writer-side hazard tracker for the simple pipeline.
- Records the destination register, write-enable and load flag of every instruction in P3 (ALU), P4 (MEM) and P5 (WB).
- Compares those against the Ra/Rb source registers of the instruction leaving decode (P2).
- Produces a load-use stall and registered forwarding selects that reach P3 on the same edge as the phase-3 control register outputs.

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Writer-side hazard tracker. Keeps {v, wr, rd, ld} for the instructions in
//   P3 (S3), P4 (S4) and P5 (S5), and compares them against the source
//   registers of the instruction leaving decode (P2). Produces a
//   combinational load-use stall and registered forwarding selects that
//   reach P3 together with the phase-3 control registers.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   id_valid              P2 holds a real instruction
//   id_ra/id_rb           source registers, id_ra_used/id_rb_used qualify them
//   id_regwrite/id_rd     destination write enable / register
//   id_memread            P2 instruction is a load
//   flush                 taken branch: squash P2 and the P3 slot
//   stall                 hold PC/P2, bubble into P3 (combinational)
//   fwd_a/fwd_b           00 regfile, 01 P4 ALU, 10 P5 write data,
//                         11 write-back-latched data
//   stall_cnt             saturating stall-cycle count
//
// Optional feature: define HAZARD_STATS_EN to build the stall_cnt port and
// counter. Without it the port and its flops do not exist.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_ra,
    input  logic [RA_W-1:0] id_rb,
    input  logic            id_ra_used,
    input  logic            id_rb_used,
    input  logic            id_regwrite,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_memread,
    input  logic            flush,
    output logic            stall,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef struct packed {
        logic            v;
        logic            wr;
        logic [RA_W-1:0] rd;
        logic            ld;
    } slot_t;

    slot_t s3, s4, s5;
    slot_t s3_d;
    logic  [1:0] fwd_a_d, fwd_b_d;
    logic  load_p3;

    function automatic logic hit(input slot_t s, input logic [RA_W-1:0] r);
        return s.v && s.wr && (s.rd == r);
    endfunction

    // Nearest writer wins, so older writes to the same register are shadowed.
    function automatic logic [1:0] sel(input logic used, input logic [RA_W-1:0] r,
                                       input slot_t a, input slot_t b, input slot_t c);
        if (!used)         return 2'b00;
        else if (hit(a, r)) return 2'b01;
        else if (hit(b, r)) return 2'b10;
        else if (hit(c, r)) return 2'b11;
        else               return 2'b00;
    endfunction

    // Only a load sitting in P3 can stall; every other distance forwards.
    always_comb begin
        stall = id_valid && !flush && s3.v && s3.wr && s3.ld &&
                ((id_ra_used && (s3.rd == id_ra)) || (id_rb_used && (s3.rd == id_rb)));
    end

    always_comb begin
        load_p3 = id_valid && !flush && !stall;
        s3_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!flush && !stall) begin
            s3_d = '{v: id_valid, wr: id_regwrite, rd: id_rd, ld: id_memread};
        end
        // Bubbles and squashed slots never forward.
        if (load_p3) begin
            fwd_a_d = sel(id_ra_used, id_ra, s3, s4, s5);
            fwd_b_d = sel(id_rb_used, id_rb, s3, s4, s5);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3    <= '0;
            s4    <= '0;
            s5    <= '0;
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
        end else begin
            s3    <= s3_d;
            s4    <= s3;
            s5    <= s4;
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        stall_cnt <= '0;
        else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
`else
    // Counter width only matters when the statistics build is enabled.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
